// File: rtl/stepper_pkg.sv
// stepper_pkg: register map, command fields, phase table and channel states
package stepper_pkg;
  localparam logic [1:0] REG_CMD = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam int CMD_DIR = 28;
  localparam int CMD_HALF = 29;
  localparam int CMD_HOLD = 30;
  localparam logic [3:0] PHASE [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  // full-step lands on odd (two-coil) entries, realigning an even start index
  function automatic logic [2:0] next_idx(logic [2:0] idx, logic half, logic dir);
    logic [1:0] q;
    q = dir ? idx[2:1] - 2'd1 : idx[2:1] + 2'd1;
    return half ? (dir ? idx - 3'd1 : idx + 3'd1) : {q, 1'b1};
  endfunction
endpackage

// File: rtl/stepper_if.sv
// stepper_if: data-memory bus port of the stepper sequencer
interface stepper_if;
  logic        wren;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] q_out;
  modport master (output wren, address, data_in, input q_out);
  modport slave (input wren, address, data_in, output q_out);
endinterface

// File: rtl/stepper_channel.sv
// stepper_channel: one motor channel with FSM, step divider, step counter and coil register
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_we,
  input  logic             period_we,
  input  logic [31:0]      data,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic [31:0]      status,
  output logic [DIV_W-1:0] period
);
  state_t state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [CNT_W-1:0] rem, rem_nx, cnt;
  logic [DIV_W-1:0] div, div_nx, reload;
  logic hold, half, dir, hold_nx, half_nx, dir_nx;
  logic start, stop, step, fin;
  logic [3:0] coils_nx;
  logic unused_ok;
  assign cnt = data[CNT_W-1:0];
  assign start = cmd_we && cnt != '0;
  assign stop = cmd_we && cnt == '0;
  assign step = state == RUN && div == '0 && !cmd_we;
  assign fin = step && rem == CNT_W'(1);
  assign reload = period == '0 ? '0 : period - DIV_W'(1);
  assign unused_ok = ^data;
  assign status = {16'(rem), 11'd0, idx, hold, busy};
  always_ff @(posedge clock)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = stop ? IDLE : start ? RUN : fin ? IDLE : state;
  // the final step pattern is driven for one cycle even when holding is off
  always_comb begin
    busy = state == RUN;
    idx_nx = step ? next_idx(idx, half, dir) : idx;
    rem_nx = start ? cnt : step ? rem - CNT_W'(1) : rem;
    div_nx = start || step ? reload : busy && div != '0 ? div - DIV_W'(1) : div;
    hold_nx = cmd_we ? data[CMD_HOLD] : hold;
    half_nx = start ? data[CMD_HALF] : half;
    dir_nx = start ? data[CMD_DIR] : dir;
    coils_nx = state_nx == RUN || hold_nx || fin ? PHASE[idx_nx] : 4'b0000;
  end
  always_ff @(posedge clock)
    if (!reset_n) begin
      idx <= '0;
      rem <= '0;
      div <= '0;
      period <= DIV_W'(1);
      hold <= 1'b0;
      half <= 1'b0;
      dir <= 1'b0;
      coils <= '0;
      done <= 1'b0;
    end else begin
      idx <= idx_nx;
      rem <= rem_nx;
      div <= div_nx;
      period <= period_we ? data[DIV_W-1:0] : period;
      hold <= hold_nx;
      half <= half_nx;
      dir <= dir_nx;
      coils <= coils_nx;
      done <= fin;
    end
endmodule

// File: rtl/stepper_ctrl.sv
// stepper_ctrl: memory-mapped multi-channel stepper sequencer (address decode and read mux)
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 16,
  parameter int DIV_W = 24
) (
  input  logic                clock,
  input  logic                reset_n,
  stepper_if.slave            bus,
  output logic [4*NUM_CH-1:0] coils,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done
);
  logic [5:0] ch;
  logic [1:0] sel;
  logic [31:0] rd;
  logic [31:0] status [NUM_CH];
  logic [DIV_W-1:0] period [NUM_CH];
  assign ch = bus.address[7:2];
  assign sel = bus.address[1:0];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stepper_channel #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .cmd_we(bus.wren && ch == 6'(c) && sel == REG_CMD),
      .period_we(bus.wren && ch == 6'(c) && sel == REG_PERIOD),
      .data(bus.data_in),
      .coils(coils[4*c+:4]),
      .busy(busy[c]),
      .done(done[c]),
      .status(status[c]),
      .period(period[c])
    );
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == 6'(i)) rd = sel == REG_PERIOD ? 32'(period[i]) : sel == REG_STATUS ? status[i] : '0;
  end
  always_ff @(posedge clock) bus.q_out <= !reset_n ? '0 : rd;
endmodule

// File: tb/tb_stepper_ctrl.sv
// tb_stepper_ctrl: directed scoreboard bench for stepper_ctrl
module tb_stepper_ctrl;
  localparam int NUM_CH = 2;
  localparam logic [3:0] TAB [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                     4'b0010, 4'b0011, 4'b0001, 4'b1001};
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [4*NUM_CH-1:0] coils;
  logic [NUM_CH-1:0] busy, done;
  exp_t sb[$];
  int total = 0, passes = 0, fails = 0;

  stepper_if bus();
  stepper_ctrl #(.NUM_CH(NUM_CH), .CNT_W(16), .DIV_W(24)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .coils(coils), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passes, total);
    $fatal(1, "watchdog");
  end

  task automatic push(string t, logic [31:0] v);
    sb.push_back('{t, v});
  endtask

  task automatic check(logic [31:0] o);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: got %h want <nothing queued>", o);
      return;
    end
    e = sb.pop_front();
    assert (o === e.v) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", e.tag, o, e.v);
    end
  endtask

  function automatic logic [31:0] cmd(int n, bit d, bit h, bit hold);
    return {1'b0, hold, h, d, 12'd0, 16'(n)};
  endfunction

  function automatic logic [7:0] adr(int c, int r);
    return {6'(c), 2'(r)};
  endfunction

  function automatic logic [31:0] ob(int c);
    return {26'd0, done[c], busy[c], coils[4*c+:4]};
  endfunction

  function automatic logic [31:0] ex(bit dn, bit bz, logic [3:0] cl);
    return {26'd0, dn, bz, cl};
  endfunction

  task automatic wr(int c, int r, logic [31:0] d);
    bus.wren = 1'b1;
    bus.address = adr(c, r);
    bus.data_in = d;
    @(negedge clock);
    bus.wren = 1'b0;
  endtask

  task automatic rd(string t, int c, int r, logic [31:0] e);
    bus.address = adr(c, r);
    push(t, e);
    @(negedge clock);
    check(bus.q_out);
  endtask

  task automatic watch(int c, int n);
    for (int k = 0; k < n; k++) begin
      if (k != 0) @(negedge clock);
      check(ob(c));
    end
  endtask

  initial begin
    bus.wren = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    push("rst_coils", 0); check(32'(coils));
    push("rst_busy", 0); check(32'(busy));
    push("rst_done", 0); check(32'(done));
    push("rst_q", 0); check(bus.q_out);
    rd("rst_period0", 0, 1, 1);
    rd("rst_status1", 1, 2, 0);

    // full-step forward, 3 steps of 4 cycles, no hold
    wr(0, 1, 4);
    for (int k = 0; k < 14; k++)
      push("t1_seq", k == 13 ? ex(0, 0, 4'b0000) : k == 12 ? ex(1, 0, 4'b1001) :
           ex(0, 1, k < 4 ? 4'b1000 : k < 8 ? 4'b0110 : 4'b0011));
    wr(0, 0, cmd(3, 0, 0, 0));
    watch(0, 14);
    rd("t1_status", 0, 2, 32'h0000_001C);

    // half-step reverse every cycle from idx 7, with hold
    wr(0, 1, 1);
    for (int k = 0; k < 11; k++) begin
      int i;
      i = k == 10 ? 6 : (7 - k) & 7;
      push("t2_seq", ex(k == 9, k < 9, TAB[i]));
    end
    wr(0, 0, cmd(9, 1, 1, 1));
    watch(0, 11);
    rd("t2_status", 0, 2, 32'h0000_001A);

    // ch1 aborted after two steps
    wr(1, 1, 2);
    rd("t3_period", 1, 1, 2);
    for (int k = 0; k < 5; k++)
      push("t3_run", ex(0, 1, k < 2 ? 4'b1000 : k < 4 ? 4'b0110 : 4'b0011));
    wr(1, 0, cmd(10, 0, 0, 0));
    watch(1, 5);
    for (int k = 0; k < 6; k++) push("t3_abort", ex(0, 0, 4'b0011));
    wr(1, 0, cmd(0, 0, 0, 1));
    watch(1, 6);
    rd("t3_period2", 1, 1, 2);
    bus.address = adr(1, 2);
    #1;
    push("t3_latency", 2); check(bus.q_out);
    push("t3_status", 32'h0008_0016);
    @(negedge clock);
    check(bus.q_out);

    // ch0 re-commanded mid-move: reverse 2 steps then one done
    wr(0, 1, 3);
    for (int k = 0; k < 7; k++)
      push("t4_first", ex(0, 1, k < 3 ? 4'b0001 : k < 6 ? 4'b1100 : 4'b0110));
    wr(0, 0, cmd(5, 0, 0, 0));
    watch(0, 7);
    for (int k = 7; k < 15; k++)
      push("t4_second", k == 14 ? ex(0, 0, 4'b0000) : k == 13 ? ex(1, 0, 4'b1001) :
           ex(0, 1, k < 10 ? 4'b0110 : 4'b1100));
    wr(0, 0, cmd(2, 1, 0, 0));
    watch(0, 8);

    // reset in the middle of moves on both channels
    wr(0, 0, cmd(100, 0, 1, 1));
    wr(1, 0, cmd(100, 0, 0, 1));
    repeat (3) @(negedge clock);
    push("t5_busy_pre", 2'b11); check(32'(busy));
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    push("t5_coils", 0); check(32'(coils));
    push("t5_busy", 0); check(32'(busy));
    push("t5_q", 0); check(bus.q_out);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      push("t5_quiet", 0); check(32'({done, busy, coils}));
    end
    rd("t5_period0", 0, 1, 1);
    rd("t5_period1", 1, 1, 1);
    wr(5, 1, 7);
    wr(5, 0, cmd(5, 0, 0, 0));
    push("t5_ch5_busy", 0); check(32'(busy));
    rd("t5_ch5_period", 5, 1, 0);
    rd("t5_ch5_status", 5, 2, 0);
    rd("t5_alias_period1", 1, 1, 1);
    rd("t5_alias_status1", 1, 2, 0);
    wr(0, 3, 32'hFFFF_FFFF);
    rd("t5_reserved", 0, 3, 0);
    rd("t5_period0_after", 0, 1, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
